// File: rtl/seq_alu_n_if.sv
// seq_alu_n_if: start/busy/done request and result bus for seq_alu_n
interface seq_alu_n_if #(parameter int WIDTH = 8);
  logic start;
  logic [3:0] ctrl;
  logic [WIDTH-1:0] A, B, Y, Y_hi;
  logic CF, OF, ZF, busy, done;
  modport master(output start, ctrl, A, B, input Y, Y_hi, CF, OF, ZF, busy, done);
  modport slave(input start, ctrl, A, B, output Y, Y_hi, CF, OF, ZF, busy, done);
endinterface

// File: rtl/seq_alu_n.sv
// seq_alu_n: registered WIDTH-bit ALU with start/busy/done handshake and shift-add multiplier
module seq_alu_n #(parameter int WIDTH = 8) (
  input logic clk,
  input logic clrn,
  seq_alu_n_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] b_op, res, mplier;
  logic [WIDTH:0] sum;
  logic [2*WIDTH-1:0] mcand, prod, prod_nxt;
  logic [SHW-1:0] cnt;
  logic cf, of, last;
  assign last = cnt == SHW'(WIDTH - 1);
  assign prod_nxt = prod + (mplier[0] ? mcand : '0);
  assign bus.busy = state == CALC;
  assign bus.done = state == DONE;
  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE ? (bus.start ? (bus.ctrl == 4'd8 ? CALC : DONE) : IDLE) :
                state == CALC ? (last ? DONE : CALC) : IDLE;
  end
  // SUB reuses the adder as A + ~B + 1, so CF is the inverted borrow
  always_comb begin
    b_op = bus.ctrl == 4'd1 ? ~bus.B : bus.B;
    sum = {1'b0, bus.A} + {1'b0, b_op} + (WIDTH+1)'(bus.ctrl == 4'd1);
    res = '0;
    cf = 1'b0;
    of = 1'b0;
    case (bus.ctrl)
      4'd0, 4'd1: begin
        res = sum[WIDTH-1:0];
        cf = sum[WIDTH];
        of = (bus.A[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != bus.A[WIDTH-1]);
      end
      4'd2: res = ~bus.A;
      4'd3: res = bus.A & bus.B;
      4'd4: res = bus.A | bus.B;
      4'd5: res = bus.A ^ bus.B;
      4'd6: res = {{(WIDTH-1){1'b0}}, $signed(bus.A) > $signed(bus.B)};
      4'd7: res = {{(WIDTH-1){1'b0}}, bus.A == bus.B};
      4'd9: res = bus.A << bus.B[SHW-1:0];
      4'd10: res = $signed(bus.A) >>> bus.B[SHW-1:0];
      4'd11: res = {{(WIDTH-1){1'b0}}, bus.A > bus.B};
      default: res = '0;
    endcase
  end
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= IDLE;
      bus.Y <= '0;
      bus.Y_hi <= '0;
      bus.CF <= 1'b0;
      bus.OF <= 1'b0;
      bus.ZF <= 1'b0;
      mcand <= '0;
      mplier <= '0;
      prod <= '0;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.start) begin
        if (bus.ctrl == 4'd8) begin
          mcand <= {{WIDTH{1'b0}}, bus.A};
          mplier <= bus.B;
          prod <= '0;
          cnt <= '0;
        end else begin
          bus.Y <= res;
          bus.Y_hi <= '0;
          bus.CF <= cf;
          bus.OF <= of;
          bus.ZF <= res == '0 && bus.ctrl < 4'd12;
        end
      end else if (state == CALC) begin
        prod <= prod_nxt;
        mcand <= mcand << 1;
        mplier <= mplier >> 1;
        cnt <= cnt + 1'b1;
        if (last) begin
          bus.Y <= prod_nxt[WIDTH-1:0];
          bus.Y_hi <= prod_nxt[2*WIDTH-1:WIDTH];
          bus.CF <= |prod_nxt[2*WIDTH-1:WIDTH];
          bus.OF <= 1'b0;
          bus.ZF <= prod_nxt == '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_seq_alu_n.sv
// tb_seq_alu_n: directed checks of seq_alu_n at WIDTH=8 and WIDTH=4
module tb_seq_alu_n;
  logic clk = 1'b0;
  logic clrn = 1'b0;
  int errors = 0;
  int checks = 0;
  seq_alu_n_if #(.WIDTH(8)) u8();
  seq_alu_n_if #(.WIDTH(4)) u4();
  seq_alu_n #(.WIDTH(8)) dut8(.clk(clk), .clrn(clrn), .bus(u8.slave));
  seq_alu_n #(.WIDTH(4)) dut4(.clk(clk), .clrn(clrn), .bus(u4.slave));
  always #5 clk = ~clk;

  task automatic go8(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
    for (int i = 0; i < 40 && (u8.busy || u8.done); i++) @(negedge clk);
    @(negedge clk);
    u8.ctrl = c; u8.A = a; u8.B = b; u8.start = 1'b1;
    @(posedge clk); #1;
    u8.start = 1'b0;
  endtask

  task automatic go4(input logic [3:0] c, input logic [3:0] a, input logic [3:0] b);
    for (int i = 0; i < 40 && (u4.busy || u4.done); i++) @(negedge clk);
    @(negedge clk);
    u4.ctrl = c; u4.A = a; u4.B = b; u4.start = 1'b1;
    @(posedge clk); #1;
    u4.start = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({u8.Y, u8.Y_hi, u8.CF, u8.OF, u8.ZF, u8.busy, u8.done} !== 21'h0) begin errors++; $display("FAIL reset8 got=%h exp=0", {u8.Y, u8.Y_hi, u8.CF, u8.OF, u8.ZF, u8.busy, u8.done}); end
    checks++; if ({u4.Y, u4.Y_hi, u4.CF, u4.OF, u4.ZF, u4.busy, u4.done} !== 13'h0) begin errors++; $display("FAIL reset4 got=%h exp=0", {u4.Y, u4.Y_hi, u4.CF, u4.OF, u4.ZF, u4.busy, u4.done}); end
    @(negedge clk) clrn = 1'b1;
  endtask

  task automatic test_add_sub;
    go8(4'd0, 8'h7F, 8'h01);
    checks++; if ({u8.done, u8.CF, u8.OF, u8.ZF, u8.Y} !== 12'hA80) begin errors++; $display("FAIL add_7f_01 got=%h exp=a80", {u8.done, u8.CF, u8.OF, u8.ZF, u8.Y}); end
    go8(4'd1, 8'h05, 8'h05);
    checks++; if ({u8.done, u8.CF, u8.OF, u8.ZF, u8.Y} !== 12'hD00) begin errors++; $display("FAIL sub_05_05 got=%h exp=d00", {u8.done, u8.CF, u8.OF, u8.ZF, u8.Y}); end
    go8(4'd1, 8'h00, 8'h01);
    checks++; if ({u8.done, u8.CF, u8.OF, u8.ZF, u8.Y} !== 12'h8FF) begin errors++; $display("FAIL sub_00_01 got=%h exp=8ff", {u8.done, u8.CF, u8.OF, u8.ZF, u8.Y}); end
  endtask

  task automatic test_logic;
    go8(4'd3, 8'hF0, 8'h3C);
    checks++; if ({u8.done, u8.CF, u8.OF, u8.ZF, u8.Y} !== 12'h830) begin errors++; $display("FAIL and got=%h exp=830", {u8.done, u8.CF, u8.OF, u8.ZF, u8.Y}); end
    go8(4'd4, 8'hF0, 8'h3C);
    checks++; if ({u8.done, u8.CF, u8.OF, u8.ZF, u8.Y} !== 12'h8FC) begin errors++; $display("FAIL or got=%h exp=8fc", {u8.done, u8.CF, u8.OF, u8.ZF, u8.Y}); end
    go8(4'd5, 8'hF0, 8'h3C);
    checks++; if ({u8.done, u8.CF, u8.OF, u8.ZF, u8.Y} !== 12'h8CC) begin errors++; $display("FAIL xor got=%h exp=8cc", {u8.done, u8.CF, u8.OF, u8.ZF, u8.Y}); end
  endtask

  task automatic test_mul;
    int n = 0;
    go8(4'd8, 8'hFF, 8'hFF);
    for (int i = 0; i < 20 && u8.busy; i++) begin
      n++;
      if (n == 3) begin u8.start = 1'b1; u8.ctrl = 4'd0; u8.A = 8'h00; u8.B = 8'h00; end
      @(posedge clk); #1;
      u8.start = 1'b0;
    end
    checks++; if (n !== 8) begin errors++; $display("FAIL mul_busy_cycles got=%0d exp=8", n); end
    checks++; if ({u8.done, u8.CF, u8.OF, u8.ZF, u8.Y_hi, u8.Y} !== 20'hC_FE01) begin errors++; $display("FAIL mul_ff_ff got=%h exp=cfe01", {u8.done, u8.CF, u8.OF, u8.ZF, u8.Y_hi, u8.Y}); end
    @(posedge clk); #1;
    checks++; if ({u8.done, u8.busy, u8.Y_hi, u8.Y} !== 18'h0_FE01) begin errors++; $display("FAIL mul_hold got=%h exp=0fe01", {u8.done, u8.busy, u8.Y_hi, u8.Y}); end
  endtask

  task automatic test_compare;
    go8(4'd6, 8'h80, 8'h01);
    checks++; if ({u8.done, u8.CF, u8.OF, u8.ZF, u8.Y} !== 12'h900) begin errors++; $display("FAIL sgt_80_01 got=%h exp=900", {u8.done, u8.CF, u8.OF, u8.ZF, u8.Y}); end
    go8(4'd11, 8'h80, 8'h01);
    checks++; if ({u8.done, u8.CF, u8.OF, u8.ZF, u8.Y} !== 12'h801) begin errors++; $display("FAIL ugt_80_01 got=%h exp=801", {u8.done, u8.CF, u8.OF, u8.ZF, u8.Y}); end
    go8(4'd6, 8'h01, 8'h80);
    checks++; if ({u8.done, u8.CF, u8.OF, u8.ZF, u8.Y} !== 12'h801) begin errors++; $display("FAIL sgt_01_80 got=%h exp=801", {u8.done, u8.CF, u8.OF, u8.ZF, u8.Y}); end
    go8(4'd7, 8'h3C, 8'h3C);
    checks++; if ({u8.done, u8.CF, u8.OF, u8.ZF, u8.Y} !== 12'h801) begin errors++; $display("FAIL eq_3c got=%h exp=801", {u8.done, u8.CF, u8.OF, u8.ZF, u8.Y}); end
  endtask

  task automatic test_shift;
    go8(4'd10, 8'h90, 8'h02);
    checks++; if ({u8.done, u8.CF, u8.OF, u8.ZF, u8.Y} !== 12'h8E4) begin errors++; $display("FAIL sra_90_2 got=%h exp=8e4", {u8.done, u8.CF, u8.OF, u8.ZF, u8.Y}); end
    go8(4'd9, 8'h90, 8'h0A);
    checks++; if ({u8.done, u8.CF, u8.OF, u8.ZF, u8.Y} !== 12'h840) begin errors++; $display("FAIL sll_90_0a got=%h exp=840", {u8.done, u8.CF, u8.OF, u8.ZF, u8.Y}); end
  endtask

  task automatic test_back_to_back;
    go8(4'd0, 8'h01, 8'h01);
    checks++; if ({u8.done, u8.Y} !== 9'h102) begin errors++; $display("FAIL b2b_first got=%h exp=102", {u8.done, u8.Y}); end
    u8.A = 8'h02; u8.B = 8'h02; u8.start = 1'b1;
    @(posedge clk); #1;
    checks++; if ({u8.done, u8.busy, u8.Y} !== 10'h002) begin errors++; $display("FAIL b2b_done_ignores_start got=%h exp=002", {u8.done, u8.busy, u8.Y}); end
    @(posedge clk); #1;
    u8.start = 1'b0;
    checks++; if ({u8.done, u8.Y} !== 9'h104) begin errors++; $display("FAIL b2b_second got=%h exp=104", {u8.done, u8.Y}); end
  endtask

  task automatic test_reset_mid_mul;
    go8(4'd8, 8'h12, 8'h34);
    repeat (2) @(posedge clk);
    @(negedge clk) clrn = 1'b0;
    #1;
    checks++; if ({u8.Y, u8.Y_hi, u8.CF, u8.OF, u8.ZF, u8.busy, u8.done} !== 21'h0) begin errors++; $display("FAIL reset_mid_mul got=%h exp=0", {u8.Y, u8.Y_hi, u8.CF, u8.OF, u8.ZF, u8.busy, u8.done}); end
    @(negedge clk) clrn = 1'b1;
    go8(4'd0, 8'h01, 8'h01);
    checks++; if ({u8.done, u8.busy, u8.CF, u8.OF, u8.ZF, u8.Y} !== 13'h1002) begin errors++; $display("FAIL add_after_reset got=%h exp=1002", {u8.done, u8.busy, u8.CF, u8.OF, u8.ZF, u8.Y}); end
  endtask

  task automatic test_width4;
    go4(4'd1, 4'h8, 4'h1);
    checks++; if ({u4.done, u4.CF, u4.OF, u4.ZF, u4.Y} !== 8'hE7) begin errors++; $display("FAIL w4_sub_8_1 got=%h exp=e7", {u4.done, u4.CF, u4.OF, u4.ZF, u4.Y}); end
    go4(4'd2, 4'h5, 4'h0);
    checks++; if ({u4.done, u4.CF, u4.OF, u4.ZF, u4.Y} !== 8'h8A) begin errors++; $display("FAIL w4_not_5 got=%h exp=8a", {u4.done, u4.CF, u4.OF, u4.ZF, u4.Y}); end
    go4(4'd3, 4'h5, 4'hA);
    checks++; if ({u4.done, u4.CF, u4.OF, u4.ZF, u4.Y} !== 8'h90) begin errors++; $display("FAIL w4_and_zero got=%h exp=90", {u4.done, u4.CF, u4.OF, u4.ZF, u4.Y}); end
    go4(4'd0, 4'hF, 4'h1);
    go4(4'd13, 4'hF, 4'hF);
    checks++; if ({u4.done, u4.CF, u4.OF, u4.ZF, u4.Y_hi, u4.Y} !== 12'h800) begin errors++; $display("FAIL w4_unused_13 got=%h exp=800", {u4.done, u4.CF, u4.OF, u4.ZF, u4.Y_hi, u4.Y}); end
    @(posedge clk); #1;
    checks++; if (u4.done !== 1'b0) begin errors++; $display("FAIL w4_done_pulse got=%b exp=0", u4.done); end
  endtask

  initial begin
    u8.start = 1'b0; u8.ctrl = '0; u8.A = '0; u8.B = '0;
    u4.start = 1'b0; u4.ctrl = '0; u4.A = '0; u4.B = '0;
    test_reset;
    test_add_sub;
    test_logic;
    test_mul;
    test_compare;
    test_shift;
    test_back_to_back;
    test_reset_mid_mul;
    test_width4;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
